// File: rtl/plic_target_ctrl.sv
// Per-target PLIC claim/complete responder: thresholds the arbiter winner into eip,
// serves claim reads and complete writes, and tracks which sources are in service.
module plic_target_ctrl #(
  parameter int NUM_IRQ  = 32,
  parameter int ID_BASE  = 1,
  parameter int PRIO_BIT = 3,
  parameter int ID_WIDTH = 6
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                arb_irq_i,
  input  logic [ID_WIDTH-1:0] arb_id_i,
  input  logic [PRIO_BIT-1:0] arb_pri_i,
  input  logic [PRIO_BIT-1:0] threshold_i,
  output logic                eip_o,
  input  logic                claim_req_i,
  output logic                claim_ack_o,
  output logic [ID_WIDTH-1:0] claim_id_o,
  input  logic                cmpl_req_i,
  input  logic [ID_WIDTH-1:0] cmpl_id_i,
  output logic                cmpl_ack_o,
  output logic [NUM_IRQ-1:0]  clr_pend_o,
  output logic [NUM_IRQ-1:0]  gw_cmpl_o,
  output logic [NUM_IRQ-1:0]  in_service_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLAIM_RSP = 2'd1,
    CMPL_RSP  = 2'd2,
    SETTLE    = 2'd3
  } state_t;

  state_t              state;
  logic                hit;
  logic [ID_WIDTH-1:0] claim_sel;

  // Out-of-range IDs (including reserved ID 0) decode to an all-zero vector.
  function automatic logic [NUM_IRQ-1:0] id_to_onehot(input logic [ID_WIDTH-1:0] id);
    logic [NUM_IRQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (int'(id) == ID_BASE + i) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  assign hit       = arb_irq_i & (arb_pri_i > threshold_i);
  assign claim_sel = hit ? arb_id_i : '0;

  // Single-process FSM; response pulses are registered on entry to the response state
  // so they are valid for exactly the one cycle spent there.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      eip_o        <= 1'b0;
      claim_ack_o  <= 1'b0;
      claim_id_o   <= '0;
      cmpl_ack_o   <= 1'b0;
      clr_pend_o   <= '0;
      gw_cmpl_o    <= '0;
      in_service_o <= '0;
    end else begin
      eip_o       <= hit & (state == IDLE) & ~claim_req_i & ~cmpl_req_i;
      claim_ack_o <= 1'b0;
      claim_id_o  <= '0;
      cmpl_ack_o  <= 1'b0;
      clr_pend_o  <= '0;
      gw_cmpl_o   <= '0;
      case (state)
        IDLE: begin
          if (claim_req_i) begin
            state       <= CLAIM_RSP;
            claim_ack_o <= 1'b1;
            claim_id_o  <= claim_sel;
            clr_pend_o  <= id_to_onehot(claim_sel);
          end else if (cmpl_req_i) begin
            // Only a source currently in service may be re-armed.
            state      <= CMPL_RSP;
            cmpl_ack_o <= 1'b1;
            gw_cmpl_o  <= id_to_onehot(cmpl_id_i) & in_service_o;
          end else begin
            state <= IDLE;
          end
        end
        CLAIM_RSP: begin
          in_service_o <= in_service_o | clr_pend_o;
          state        <= SETTLE;
        end
        CMPL_RSP: begin
          in_service_o <= in_service_o & ~gw_cmpl_o;
          state        <= SETTLE;
        end
        SETTLE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plic_target_ctrl.sv
// Directed self-checking bench for plic_target_ctrl; outputs sampled on the falling edge.
module tb_plic_target_ctrl;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        arb_irq_i;
  logic [5:0]  arb_id_i;
  logic [2:0]  arb_pri_i;
  logic [2:0]  threshold_i;
  logic        eip_o;
  logic        claim_req_i;
  logic        claim_ack_o;
  logic [5:0]  claim_id_o;
  logic        cmpl_req_i;
  logic [5:0]  cmpl_id_i;
  logic        cmpl_ack_o;
  logic [31:0] clr_pend_o;
  logic [31:0] gw_cmpl_o;
  logic [31:0] in_service_o;

  int checks = 0;
  int errors = 0;

  plic_target_ctrl #(.NUM_IRQ(32), .ID_BASE(1), .PRIO_BIT(3), .ID_WIDTH(6)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .arb_irq_i(arb_irq_i), .arb_id_i(arb_id_i), .arb_pri_i(arb_pri_i),
    .threshold_i(threshold_i), .eip_o(eip_o),
    .claim_req_i(claim_req_i), .claim_ack_o(claim_ack_o), .claim_id_o(claim_id_o),
    .cmpl_req_i(cmpl_req_i), .cmpl_id_i(cmpl_id_i), .cmpl_ack_o(cmpl_ack_o),
    .clr_pend_o(clr_pend_o), .gw_cmpl_o(gw_cmpl_o), .in_service_o(in_service_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n_i     = 1'b0;
    arb_irq_i   = 1'b1;
    arb_id_i    = 6'd5;
    arb_pri_i   = 3'd3;
    threshold_i = 3'd1;
    claim_req_i = 1'b0;
    cmpl_req_i  = 1'b0;
    cmpl_id_i   = 6'd0;

    // 1: reset state, then eip one cycle after release
    tick(); tick();
    check("rst_eip", 64'(eip_o), 64'd0);
    check("rst_claim_ack", 64'(claim_ack_o), 64'd0);
    check("rst_in_service", 64'(in_service_o), 64'd0);
    rst_n_i = 1'b1;
    tick();
    check("eip_after_rst", 64'(eip_o), 64'd1);

    // 2: claim id 5
    claim_req_i = 1'b1;
    tick();
    check("c2_ack", 64'(claim_ack_o), 64'd1);
    check("c2_id", 64'(claim_id_o), 64'd5);
    check("c2_clr", 64'(clr_pend_o), 64'h10);
    check("c2_eip_rsp", 64'(eip_o), 64'd0);
    check("c2_insvc_rsp", 64'(in_service_o), 64'd0);
    claim_req_i = 1'b0;
    tick();
    check("c2_ack_drop", 64'(claim_ack_o), 64'd0);
    check("c2_clr_drop", 64'(clr_pend_o), 64'd0);
    check("c2_insvc", 64'(in_service_o), 64'h10);
    check("c2_eip_settle", 64'(eip_o), 64'd0);
    tick();
    check("c2_eip_idle0", 64'(eip_o), 64'd0);
    tick();
    check("c2_eip_back", 64'(eip_o), 64'd1);

    // live threshold: raising it to 3 masks the priority-3 winner
    threshold_i = 3'd3;
    tick();
    check("thr_mask_eip", 64'(eip_o), 64'd0);

    // 3: pri 2 vs thr 2 is not strictly greater
    arb_pri_i   = 3'd2;
    threshold_i = 3'd2;
    claim_req_i = 1'b1;
    tick();
    check("c3_ack", 64'(claim_ack_o), 64'd1);
    check("c3_id", 64'(claim_id_o), 64'd0);
    check("c3_clr", 64'(clr_pend_o), 64'd0);
    claim_req_i = 1'b0;
    tick();
    check("c3_insvc", 64'(in_service_o), 64'h10);
    tick();

    // 4: complete id 5, then a repeated complete
    cmpl_req_i = 1'b1;
    cmpl_id_i  = 6'd5;
    tick();
    check("c4_ack", 64'(cmpl_ack_o), 64'd1);
    check("c4_gw", 64'(gw_cmpl_o), 64'h10);
    check("c4_claim_ack", 64'(claim_ack_o), 64'd0);
    cmpl_req_i = 1'b0;
    tick();
    check("c4_insvc", 64'(in_service_o), 64'd0);
    check("c4_gw_drop", 64'(gw_cmpl_o), 64'd0);
    tick();
    cmpl_req_i = 1'b1;
    tick();
    check("c4r_ack", 64'(cmpl_ack_o), 64'd1);
    check("c4r_gw", 64'(gw_cmpl_o), 64'd0);
    cmpl_req_i = 1'b0;
    tick();
    check("c4r_insvc", 64'(in_service_o), 64'd0);
    tick();

    // 5: re-claim id 5, then bogus completes with id 0 and id 40
    arb_pri_i   = 3'd3;
    threshold_i = 3'd1;
    claim_req_i = 1'b1;
    tick();
    check("c5_claim_id", 64'(claim_id_o), 64'd5);
    claim_req_i = 1'b0;
    tick(); tick();
    cmpl_req_i = 1'b1;
    cmpl_id_i  = 6'd0;
    tick();
    check("c5_id0_ack", 64'(cmpl_ack_o), 64'd1);
    check("c5_id0_gw", 64'(gw_cmpl_o), 64'd0);
    cmpl_req_i = 1'b0;
    tick();
    check("c5_id0_insvc", 64'(in_service_o), 64'h10);
    tick();
    cmpl_req_i = 1'b1;
    cmpl_id_i  = 6'd40;
    tick();
    check("c5_id40_ack", 64'(cmpl_ack_o), 64'd1);
    check("c5_id40_gw", 64'(gw_cmpl_o), 64'd0);
    cmpl_req_i = 1'b0;
    tick();
    check("c5_id40_insvc", 64'(in_service_o), 64'h10);
    tick();

    // 5: simultaneous claim (winner id 7) and complete (id 5)
    arb_id_i    = 6'd7;
    claim_req_i = 1'b1;
    cmpl_req_i  = 1'b1;
    cmpl_id_i   = 6'd5;
    tick();
    check("sim_claim_ack", 64'(claim_ack_o), 64'd1);
    check("sim_claim_id", 64'(claim_id_o), 64'd7);
    check("sim_clr", 64'(clr_pend_o), 64'h40);
    check("sim_cmpl_ack_early", 64'(cmpl_ack_o), 64'd0);
    claim_req_i = 1'b0;
    tick();
    check("sim_insvc", 64'(in_service_o), 64'h50);
    check("sim_cmpl_ack_settle", 64'(cmpl_ack_o), 64'd0);
    tick();
    check("sim_cmpl_ack_idle", 64'(cmpl_ack_o), 64'd0);
    tick();
    check("sim_cmpl_ack", 64'(cmpl_ack_o), 64'd1);
    check("sim_gw", 64'(gw_cmpl_o), 64'h10);
    check("sim_clr_none", 64'(clr_pend_o), 64'd0);
    cmpl_req_i = 1'b0;
    tick();
    check("sim_insvc_after", 64'(in_service_o), 64'h40);
    tick();

    // 6: reset asserted during CLAIM_RSP
    arb_id_i    = 6'd5;
    claim_req_i = 1'b1;
    tick();
    check("r6_ack_before", 64'(claim_ack_o), 64'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("r6_ack", 64'(claim_ack_o), 64'd0);
    check("r6_clr", 64'(clr_pend_o), 64'd0);
    check("r6_insvc", 64'(in_service_o), 64'd0);
    check("r6_eip", 64'(eip_o), 64'd0);
    claim_req_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    tick();
    check("r6_no_ack", 64'(claim_ack_o), 64'd0);
    check("r6_no_cmpl_ack", 64'(cmpl_ack_o), 64'd0);
    check("r6_eip_idle", 64'(eip_o), 64'd1);
    tick();
    check("r6_no_ack2", 64'(claim_ack_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plic_target_ctrl.md
Name: plic_target_ctrl

Overview:
Per-target claim/complete responder that consumes the winner (valid, ID, priority) from the PLIC priority arbiter.
- Applies the target's priority threshold and drives the registered external-interrupt-pending line to the hart.
- Serves claim reads: returns the winning ID and pulses the matching gateway pending-clear.
- Serves complete writes: pulses the matching gateway completion to re-arm it.
- Tracks in-service sources so that bogus completions are ignored.

Parameters:
NUM_IRQ, 32, number of interrupt sources feeding this target.
ID_BASE, 1, global ID of source index 0. ID 0 is reserved and means "no interrupt".
PRIO_BIT, 3, priority and threshold width.
ID_WIDTH, 6, ID width. Must hold ID_BASE+NUM_IRQ-1.

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
arb_irq_i  input  1  arbiter has an enabled, pending winner
arb_id_i  input  ID_WIDTH  winner global ID
arb_pri_i  input  PRIO_BIT  winner priority
threshold_i  input  PRIO_BIT  target priority threshold
eip_o  output  1  external interrupt pending to hart
claim_req_i  input  1  claim-register read request; level, held until ack
claim_ack_o  output  1  one-cycle claim acknowledge
claim_id_o  output  ID_WIDTH  claimed ID; valid while claim_ack_o=1, else 0
cmpl_req_i  input  1  complete-register write request; level, held until ack
cmpl_id_i  input  ID_WIDTH  ID being completed
cmpl_ack_o  output  1  one-cycle complete acknowledge
clr_pend_o  output  NUM_IRQ  one-hot pending-clear pulse to gateways
gw_cmpl_o  output  NUM_IRQ  one-hot completion pulse to gateways
in_service_o  output  NUM_IRQ  claimed-but-not-completed bitmap

Behaviour:
- Reset is asynchronous and active-low. All outputs, the state and the capture registers reset to 0; state resets to IDLE.
- Qualification: hit = arb_irq_i & (arb_pri_i > threshold_i), strictly greater. Priority 0 therefore never interrupts.
- eip_o is a register: eip_o <= hit & (state==IDLE) & ~claim_req_i & ~cmpl_req_i. Latency is 1 cycle from input change.
- FSM states: IDLE, CLAIM_RSP, CMPL_RSP, SETTLE.
- IDLE:
  - If claim_req_i: capture cap_id = hit ? arb_id_i : 0, go to CLAIM_RSP.
  - Else if cmpl_req_i: capture cmpl_id_i, go to CMPL_RSP.
  - Claim wins when both are requested in the same cycle; the complete stays pending, since its req is held.
- CLAIM_RSP (exactly one cycle):
  - claim_ack_o=1, claim_id_o=cap_id.
  - If cap_id≠0, let idx=cap_id-ID_BASE: clr_pend_o[idx]=1 and in_service[idx] is set at the next edge.
  - Next state is SETTLE.
- CMPL_RSP (exactly one cycle):
  - cmpl_ack_o=1.
  - If the captured ID is in range (ID_BASE ≤ id < ID_BASE+NUM_IRQ) and in_service[idx]=1: gw_cmpl_o[idx]=1 and in_service[idx] is cleared.
  - Otherwise there is no pulse and no state change. The ack is still given.
  - Next state is SETTLE.
- SETTLE: one cycle, so the gateway/arbiter update propagates before the next request or eip evaluation. Then IDLE.
- Handshake:
  - Requester deasserts req in the cycle after ack.
  - A req still high in IDLE after SETTLE is a new request.
  - Minimum request-to-request spacing is 3 cycles.
- Latency:
  - Claim: req sampled at edge T, ack during cycle T+1.
  - Complete: same.
- Out-of-range arb_id_i with hit=1: claim returns that ID and no clr_pend pulse is issued. This cannot occur with correct parameters.
- Claiming an already-in-service ID is legal (re-trigger after gateway re-arm); the in_service bit stays set.
- clr_pend_o and gw_cmpl_o are never both nonzero in the same cycle. Each is at most one-hot.
- Reset mid-transaction: everything clears immediately, and in-flight acks are lost. The requester must reissue.
- threshold_i is sampled live and is not latched. A change takes effect on eip_o one cycle later.

Test Plan:
1. Reset release with arb_irq_i=1, id=5, pri=3, thr=1 → eip_o=0 during reset and 1 one cycle after rst_n_i rises.
2. Claim with id=5, pri=3, thr=1 → claim_ack_o=1 and claim_id_o=5 at T+1, clr_pend_o=bit 4 for one cycle, in_service_o[4]=1, eip_o=0 through CLAIM_RSP/SETTLE.
3. Claim with pri=2, thr=2 (not greater) → claim_id_o=0, no clr_pend pulse, in_service unchanged.
4. Complete id=5 after test 2 → cmpl_ack_o=1, gw_cmpl_o=bit 4, in_service_o[4]=0. Repeat complete id=5 → ack only, gw_cmpl_o=0.
5. Complete with id=0 and id=40 → ack, no pulse, no bitmap change. Simultaneous claim_req_i and cmpl_req_i in IDLE → claim acked first, complete acked 3 cycles later.
6. rst_n_i asserted in CLAIM_RSP → claim_ack_o, clr_pend_o, in_service_o and eip_o all 0 asynchronously. After release, state is IDLE and no spurious ack appears.
